// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer: FSM state encoding and
// the counter width function.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        StHold    = 2'd0,
        StRelease = 2'd1,
        StRun     = 2'd2
    } seq_state_e;

    // Width of a counter that must hold values 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Soft-reset handshake and sequenced reset outputs of the reset sequencer.
// The slave modport is the sequencer side.
interface reset_sequencer_if #(
    parameter int unsigned NumChan = 4
);
    logic               sw_rst_req;
    logic               sw_rst_ack;
    logic [NumChan-1:0] out_rst;
    logic               all_released;

    modport master (
        output sw_rst_req,
        input  sw_rst_ack,
        input  out_rst,
        input  all_released
    );

    modport slave (
        input  sw_rst_req,
        output sw_rst_ack,
        output out_rst,
        output all_released
    );
endinterface

// File: rtl/reset_sync_cell.sv
// Reset synchroniser: asserts asynchronously, deasserts after Stages rising
// edges of clk_i.
module reset_sync_cell #(
    parameter int unsigned Stages = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    output logic rst_sync_no
);

    (* ASYNC_REG = "TRUE" *) logic [Stages-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], 1'b1};
        end
    end

    assign rst_sync_no = sync_q[Stages-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds every channel in reset for MinAssert
// cycles, then releases channel 0 first and one more every GapCycles.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned NumChan     = 4,
    parameter int unsigned SyncStages  = 2,
    parameter int unsigned MinAssert   = 16,
    parameter int unsigned GapCycles   = 8,
    parameter bit          OutPositive = 1'b1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    reset_sequencer_if.slave  bus_io
);

    localparam int unsigned HoldW = cnt_width(MinAssert);
    localparam int unsigned GapW  = cnt_width(GapCycles);
    localparam int unsigned ChanW = $clog2(NumChan) + 1;

    localparam logic [HoldW-1:0] HoldLast = HoldW'(MinAssert - 1);
    localparam logic [GapW-1:0]  GapLast  = GapW'(GapCycles - 1);
    localparam logic [ChanW-1:0] ChanLast = ChanW'(NumChan - 1);

    logic sync_rst_n;

    reset_sync_cell #(
        .Stages (SyncStages)
    ) u_sync (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rst_sync_no (sync_rst_n)
    );

    seq_state_e         state_q, state_d;
    logic [HoldW-1:0]   hold_q, hold_d;
    logic [GapW-1:0]    gap_q, gap_d;
    logic [ChanW-1:0]   chan_q, chan_d;
    // Bit k high means channel k is held in reset; shifts left on each release.
    logic [NumChan-1:0] mask_q, mask_d;
    logic               all_rel_q, all_rel_d;
    logic               ack_q, ack_d;
    logic               pend_q, pend_d;

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        gap_d     = gap_q;
        chan_d    = chan_q;
        mask_d    = mask_q;
        all_rel_d = all_rel_q;
        ack_d     = 1'b0;
        pend_d    = pend_q;

        if (sync_rst_n) begin
            if (bus_io.sw_rst_req) begin
                state_d   = StHold;
                hold_d    = '0;
                gap_d     = '0;
                chan_d    = '0;
                mask_d    = '1;
                all_rel_d = 1'b0;
                pend_d    = 1'b1;
            end else begin
                unique case (state_q)
                    StHold: begin
                        if (hold_q == HoldLast) begin
                            hold_d = '0;
                            mask_d = mask_q << 1;
                            if (NumChan == 1) begin
                                state_d   = StRun;
                                all_rel_d = 1'b1;
                                ack_d     = pend_q;
                                pend_d    = 1'b0;
                            end else begin
                                state_d = StRelease;
                                chan_d  = ChanW'(1);
                            end
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                    StRelease: begin
                        if (gap_q == GapLast) begin
                            gap_d  = '0;
                            mask_d = mask_q << 1;
                            chan_d = chan_q + 1'b1;
                            if (chan_q == ChanLast) begin
                                state_d   = StRun;
                                all_rel_d = 1'b1;
                                ack_d     = pend_q;
                                pend_d    = 1'b0;
                            end
                        end else begin
                            gap_d = gap_q + 1'b1;
                        end
                    end
                    StRun: begin
                        state_d = StRun;
                    end
                    default: begin
                        state_d = StHold;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StHold;
            hold_q    <= '0;
            gap_q     <= '0;
            chan_q    <= '0;
            mask_q    <= '1;
            all_rel_q <= 1'b0;
            ack_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
            chan_q    <= chan_d;
            mask_q    <= mask_d;
            all_rel_q <= all_rel_d;
            ack_q     <= ack_d;
            pend_q    <= pend_d;
        end
    end

    assign bus_io.out_rst      = OutPositive ? mask_q : ~mask_q;
    assign bus_io.all_released = all_rel_q;
    assign bus_io.sw_rst_ack   = ack_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random soft/board resets,
// checked against an edge-count model of the release schedule.
module tb_reset_sequencer;

    localparam int unsigned N    = 4;
    localparam int unsigned SYNC = 2;
    localparam int unsigned MIN  = 16;
    localparam int unsigned GAP  = 8;
    localparam int unsigned LAST = MIN + (N - 1) * GAP;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    reset_sequencer_if #(.NumChan(N)) bus ();
    reset_sequencer_if #(.NumChan(1)) bus1 ();

    reset_sequencer #(
        .NumChan     (N),
        .SyncStages  (SYNC),
        .MinAssert   (MIN),
        .GapCycles   (GAP),
        .OutPositive (1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus)
    );

    reset_sequencer #(
        .NumChan     (1),
        .SyncStages  (2),
        .MinAssert   (1),
        .GapCycles   (1),
        .OutPositive (1'b0)
    ) dut1 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus_io (bus1)
    );

    // Reference: edges counted since RST_N went high; channel k is released once
    // edges >= ref_e + MIN + k*GAP, where ref_e is SYNC or the last soft request edge.
    int unsigned edges;
    int unsigned ref_e;
    bit          pend;
    bit          m_ack;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edges <= 0;
            ref_e <= SYNC;
            pend  <= 1'b0;
            m_ack <= 1'b0;
        end else begin
            edges <= edges + 1;
            m_ack <= 1'b0;
            if (bus.sw_rst_req && (edges + 1 > SYNC)) begin
                ref_e <= edges + 1;
                pend  <= 1'b1;
            end else if (pend && (edges + 1 == ref_e + LAST)) begin
                m_ack <= 1'b1;
                pend  <= 1'b0;
            end
        end
    end

    function automatic logic [N-1:0] exp_rst();
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = (edges < ref_e + MIN + k * GAP);
        return r;
    endfunction

    function automatic logic exp_all();
        return (edges >= ref_e + LAST);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        total++;
        if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== {4'hF, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_state: got rst=%b all=%b ack=%b want rst=1111 all=0 ack=0",
                     bus.out_rst, bus.all_released, bus.sw_rst_ack);
        end
        total++;
        if ({bus1.out_rst, bus1.all_released} !== 2'b00) begin
            bad++;
            $display("FAIL reset_state_single: got rst=%b all=%b want rst=0 all=0",
                     bus1.out_rst, bus1.all_released);
        end
    endtask

    task automatic test_power_up();
        int acks = 0;
        rst_n = 1'b1;
        for (int e = 1; e <= 46; e++) begin
            @(negedge clk);
            acks += int'(bus.sw_rst_ack);
            total++;
            if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== {exp_rst(), exp_all(), m_ack}) begin
                bad++;
                $display("FAIL power_up_model edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         bus.out_rst, bus.all_released, bus.sw_rst_ack, exp_rst(), exp_all(), m_ack);
            end
            if (e == 17 || e == 18 || e == 26 || e == 34 || e == 42) begin
                logic [3:0] want;
                want = (e == 17) ? 4'hF : (e == 18) ? 4'hE : (e == 26) ? 4'hC :
                       (e == 34) ? 4'h8 : 4'h0;
                total++;
                if ({bus.out_rst, bus.all_released} !== {want, (e == 42)}) begin
                    bad++;
                    $display("FAIL power_up_sched edge %0d: got rst=%b all=%b want rst=%b all=%b",
                             e, bus.out_rst, bus.all_released, want, (e == 42));
                end
            end
            if (e == 2 || e == 3) begin
                total++;
                if ({bus1.out_rst, bus1.all_released} !== {(e == 3), (e == 3)}) begin
                    bad++;
                    $display("FAIL single_chan edge %0d: got rst=%b all=%b want %b", e,
                             bus1.out_rst, bus1.all_released, (e == 3));
                end
            end
        end
        total++;
        if (acks != 0) begin
            bad++;
            $display("FAIL power_up_no_ack: got %0d acks want 0", acks);
        end
    endtask

    task automatic test_glitch();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #0.5;
        total++;
        if (bus.out_rst !== 4'hF) begin
            bad++;
            $display("FAIL glitch_async: got rst=%b want 1111", bus.out_rst);
        end
        #0.5 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({bus.out_rst, bus.all_released} !== {4'hF, 1'b0}) begin
            bad++;
            $display("FAIL glitch_hold: got rst=%b all=%b want 1111/0", bus.out_rst, bus.all_released);
        end
        for (int e = 1; e <= 46; e++) begin
            @(negedge clk);
            total++;
            if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== {exp_rst(), exp_all(), m_ack}) begin
                bad++;
                $display("FAIL glitch_model edge %0d: got %b/%b/%b want %b/%b/%b", e,
                         bus.out_rst, bus.all_released, bus.sw_rst_ack, exp_rst(), exp_all(), m_ack);
            end
            if (e == 18) begin
                total++;
                if (bus.out_rst !== 4'hE) begin
                    bad++;
                    $display("FAIL glitch_sched edge 18: got rst=%b want 1110", bus.out_rst);
                end
            end
        end
    endtask

    task automatic test_soft_req();
        int acks = 0;
        for (int i = 0; i <= 50; i++) begin
            bus.sw_rst_req = (i == 0);
            @(negedge clk);
            acks += int'(bus.sw_rst_ack);
            total++;
            if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== {exp_rst(), exp_all(), m_ack}) begin
                bad++;
                $display("FAIL soft_model t+%0d: got %b/%b/%b want %b/%b/%b", i,
                         bus.out_rst, bus.all_released, bus.sw_rst_ack, exp_rst(), exp_all(), m_ack);
            end
            if (i == 15 || i == 16 || i == 39 || i == 40) begin
                logic [5:0] want;
                want = (i == 15) ? 6'b1111_0_0 : (i == 16) ? 6'b1110_0_0 :
                       (i == 39) ? 6'b1000_0_0 : 6'b0000_1_1;
                total++;
                if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== want) begin
                    bad++;
                    $display("FAIL soft_sched t+%0d: got %b/%b/%b want %b", i, bus.out_rst,
                             bus.all_released, bus.sw_rst_ack, want);
                end
            end
        end
        bus.sw_rst_req = 1'b0;
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL soft_ack_count: got %0d want 1", acks);
        end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        for (int i = 0; i <= 70; i++) begin
            bus.sw_rst_req = (i == 0 || i == 20);
            @(negedge clk);
            acks += int'(bus.sw_rst_ack);
            total++;
            if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== {exp_rst(), exp_all(), m_ack}) begin
                bad++;
                $display("FAIL b2b_model t+%0d: got %b/%b/%b want %b/%b/%b", i,
                         bus.out_rst, bus.all_released, bus.sw_rst_ack, exp_rst(), exp_all(), m_ack);
            end
            if (i == 19 || i == 20 || i == 36 || i == 60) begin
                logic [5:0] want;
                want = (i == 19) ? 6'b1110_0_0 : (i == 20) ? 6'b1111_0_0 :
                       (i == 36) ? 6'b1110_0_0 : 6'b0000_1_1;
                total++;
                if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== want) begin
                    bad++;
                    $display("FAIL b2b_sched t+%0d: got %b/%b/%b want %b", i, bus.out_rst,
                             bus.all_released, bus.sw_rst_ack, want);
                end
            end
        end
        bus.sw_rst_req = 1'b0;
        total++;
        if (acks != 1) begin
            bad++;
            $display("FAIL b2b_ack_count: got %0d want 1", acks);
        end
    endtask

    task automatic test_req_then_rst();
        int acks = 0;
        for (int i = 0; i <= 70; i++) begin
            rst_n = !(i >= 10 && i < 13);
            bus.sw_rst_req = (i == 0);
            @(negedge clk);
            acks += int'(bus.sw_rst_ack);
            total++;
            if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== {exp_rst(), exp_all(), m_ack}) begin
                bad++;
                $display("FAIL req_rst_model t+%0d: got %b/%b/%b want %b/%b/%b", i,
                         bus.out_rst, bus.all_released, bus.sw_rst_ack, exp_rst(), exp_all(), m_ack);
            end
        end
        bus.sw_rst_req = 1'b0;
        total++;
        if (acks != 0 || bus.all_released !== 1'b1) begin
            bad++;
            $display("FAIL req_rst_no_ack: got acks=%0d all=%b want acks=0 all=1", acks,
                     bus.all_released);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            bus.sw_rst_req = ($urandom_range(0, 29) == 0);
            @(negedge clk);
            total++;
            if ({bus.out_rst, bus.all_released, bus.sw_rst_ack} !== {exp_rst(), exp_all(), m_ack}) begin
                bad++;
                $display("FAIL random_model cycle %0d: got %b/%b/%b want %b/%b/%b", i,
                         bus.out_rst, bus.all_released, bus.sw_rst_ack, exp_rst(), exp_all(), m_ack);
            end
        end
        bus.sw_rst_req = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.sw_rst_req  = 1'b0;
        bus1.sw_rst_req = 1'b0;
        test_reset();
        test_power_up();
        test_glitch();
        test_soft_req();
        test_back_to_back();
        test_req_then_rst();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
